// File: rtl/beatmap_reader_if.sv
// Downstream block hand-off between beatmap_reader (master) and the game state tracker (slave).
// A record transfers on every clock edge where block_valid_out && block_ready_in; once valid is
// raised, block_data_out holds steady and valid stays high until that edge (or a stop/reset).
interface beatmap_reader_if;
    logic        block_valid_out;
    logic        block_ready_in;
    logic [31:0] block_data_out;
    logic        block_position_ready;

    modport master (
        output block_valid_out,
        output block_data_out,
        output block_position_ready,
        input  block_ready_in
    );

    modport slave (
        input  block_valid_out,
        input  block_data_out,
        input  block_position_ready,
        output block_ready_in
    );
endinterface

// File: rtl/beatmap_reader.sv
// Walks the beatmap ROM and releases each block record once game time is within LOOKAHEAD of it.
// Optional feature macro: BEATMAP_DROP_STALE_EN (skip records whose hit time is already past).
module beatmap_reader #(
    parameter int NUM_BLOCKS = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int LOOKAHEAD  = 100
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            state_in,
    input  logic [17:0]           curr_time_in,
    output logic [ADDR_WIDTH-1:0] rom_addr_out,
    input  logic [31:0]           rom_data_in,
    beatmap_reader_if.master      blk,
    output logic                  done_out,
    output logic [7:0]            drop_count_out,
    output logic [2:0]            state_dbg_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CHECK   = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rec_q, rec_d;
    logic                  wait_q, wait_d;

    logic        playing;
    logic        handoff;
    logic        due;
    logic        sentinel;
    logic        last_rec;
    logic [17:0] hit_time;

    assign playing  = (state_in == 2'd1);
    assign hit_time = rec_q[31:14];
    assign handoff  = (state_q == S_PRESENT) && blk.block_ready_in;
    // 19-bit compare so a game time near 18'h3FFFF cannot wrap past the hit time.
    assign due      = ({1'b0, curr_time_in} + 19'(LOOKAHEAD)) >= {1'b0, hit_time};
    assign sentinel = (hit_time == 18'h3FFFF);
    assign last_rec = (addr_q == ADDR_WIDTH'(NUM_BLOCKS - 1));

`ifdef BEATMAP_DROP_STALE_EN
    logic [7:0] drop_q, drop_d;
    logic       stale;

    assign stale          = (hit_time < curr_time_in);
    assign drop_count_out = drop_q;
`else
    assign drop_count_out = 8'd0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rec_d   = rec_q;
        wait_d  = 1'b0;
`ifdef BEATMAP_DROP_STALE_EN
        drop_d  = drop_q;
`endif
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (playing) state_d = S_FETCH;
            end
            S_FETCH: begin
                // First FETCH cycle only arms wait_q; the ROM output is taken on the second.
                if (wait_q) begin
                    rec_d   = rom_data_in;
                    state_d = S_CHECK;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (sentinel) begin
                    state_d = S_DONE;
                end
`ifdef BEATMAP_DROP_STALE_EN
                else if (stale) begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    if (last_rec) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
`endif
                else if (due) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (handoff) begin
                    if (last_rec) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // Leaving PLAYING overrides everything, including a hand-off in this same cycle.
        if (!playing) begin
            state_d = S_IDLE;
            addr_d  = '0;
            rec_d   = '0;
            wait_d  = 1'b0;
`ifdef BEATMAP_DROP_STALE_EN
            drop_d  = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rec_q   <= '0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rec_q   <= rec_d;
            wait_q  <= wait_d;
        end
    end

`ifdef BEATMAP_DROP_STALE_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) drop_q <= 8'd0;
        else         drop_q <= drop_d;
    end
`endif

    // Valid and done decode the state register; the pulse is that registered valid qualified by ready.
    assign blk.block_valid_out      = (state_q == S_PRESENT);
    assign blk.block_data_out       = rec_q;
    assign blk.block_position_ready = handoff;
    assign done_out                 = (state_q == S_DONE);
    assign rom_addr_out             = addr_q;
    assign state_dbg_out            = state_q;

endmodule

// File: tb/tb_beatmap_reader.sv
// Bench for beatmap_reader: cycle vector table for the main walk, then hand-written
// sequences for stop/replay, asynchronous reset, lookahead near time wrap and end of map.
module tb_beatmap_reader;

    localparam int NB = 8;
    localparam int AW = 3;

    logic          clk_in;
    logic          rst_in;
    logic [1:0]    state_in;
    logic [17:0]   curr_time_in;
    logic [AW-1:0] rom_addr_out;
    logic [31:0]   rom_data_in;
    logic          done_out;
    logic [7:0]    drop_count_out;
    logic [2:0]    state_dbg_out;

    beatmap_reader_if bif ();

    beatmap_reader #(.NUM_BLOCKS(NB), .ADDR_WIDTH(AW), .LOOKAHEAD(100)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .state_in       (state_in),
        .curr_time_in   (curr_time_in),
        .rom_addr_out   (rom_addr_out),
        .rom_data_in    (rom_data_in),
        .blk            (bif.master),
        .done_out       (done_out),
        .drop_count_out (drop_count_out),
        .state_dbg_out  (state_dbg_out)
    );

    // Clock / reset block
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Beatmap ROM model: registered read
    logic [31:0] rom_mem [NB];
    always @(posedge clk_in) rom_data_in <= rom_mem[rom_addr_out];

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [1:0]  st;
        logic [17:0] t;
        logic        rdy;
        logic        ev;
        logic        ep;
        logic        ed;
        logic [2:0]  ea;
        logic [31:0] edat;
    } vec_t;

    vec_t vec_q [$];

    localparam logic [31:0] REC0 = {18'd50, 14'h0A51};
    localparam logic [31:0] REC1 = {18'd300, 14'h1C3F};
    localparam logic [31:0] SENT = {18'h3FFFF, 14'h0000};
    localparam logic [31:0] RECW = {18'h3FFFE, 14'h0155};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [1:0] st, input logic [17:0] t, input logic rdy,
                                input logic ev, input logic ep, input logic ed,
                                input logic [2:0] ea, input logic [31:0] edat);
        vec_t v;
        v.st = st; v.t = t; v.rdy = rdy; v.ev = ev; v.ep = ep; v.ed = ed; v.ea = ea; v.edat = edat;
        vec_q.push_back(v);
    endfunction

    // Driver: called at a negedge with inputs set; counts edges until valid shows up.
    task automatic run_until_valid(input int max_cyc, output int n);
        n = 0;
        #1;
        while (!bif.block_valid_out && n < max_cyc) begin
            @(negedge clk_in);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_pulses;
        int pulses;
        vec_t v;

        for (int i = 0; i < NB; i++) rom_mem[i] = SENT;
        rom_mem[0] = REC0;
        rom_mem[1] = REC1;
        rom_mem[2] = SENT;

        rst_in = 1'b0;
        state_in = 2'd0;
        curr_time_in = 18'd0;
        bif.block_ready_in = 1'b0;
        #2;
        check("reset_valid", {31'd0, bif.block_valid_out}, 32'd0);
        check("reset_data", bif.block_data_out, 32'd0);
        check("reset_done", {31'd0, done_out}, 32'd0);
        check("reset_drop", {24'd0, drop_count_out}, 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;

        // Main walk: record 0 due at once, record 1 due at t=200, record 2 is the sentinel.
        add(2'd0, 18'd0, 1'b1, 0, 0, 0, 3'd0, 32'd0);
        for (int i = 0; i < 4; i++) add(2'd1, 18'd0, 1'b1, 0, 0, 0, 3'd0, 32'd0);
        add(2'd1, 18'd0, 1'b1, 1, 1, 0, 3'd0, REC0);
        for (int i = 0; i < 4; i++) add(2'd1, 18'd199, 1'b0, 0, 0, 0, 3'd1, 32'd0);
        add(2'd1, 18'd200, 1'b0, 0, 0, 0, 3'd1, 32'd0);
        for (int i = 0; i < 20; i++) add(2'd1, 18'(200 + i), 1'b0, 1, 0, 0, 3'd1, REC1);
        add(2'd1, 18'd220, 1'b1, 1, 1, 0, 3'd1, REC1);
        for (int i = 0; i < 3; i++) add(2'd1, 18'd220, 1'b1, 0, 0, 0, 3'd2, 32'd0);
        for (int i = 0; i < 2; i++) add(2'd1, 18'd220, 1'b1, 0, 0, 1, 3'd2, 32'd0);
        add(2'd0, 18'd220, 1'b1, 0, 0, 1, 3'd2, 32'd0);
        add(2'd0, 18'd220, 1'b1, 0, 0, 0, 3'd0, 32'd0);

        @(negedge clk_in);
        for (int i = 0; i < vec_q.size(); i++) begin
            v = vec_q[i];
            state_in = v.st;
            curr_time_in = v.t;
            bif.block_ready_in = v.rdy;
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, bif.block_valid_out}, {31'd0, v.ev});
            check($sformatf("vec%0d_pulse", i), {31'd0, bif.block_position_ready}, {31'd0, v.ep});
            check($sformatf("vec%0d_done", i), {31'd0, done_out}, {31'd0, v.ed});
            check($sformatf("vec%0d_addr", i), {29'd0, rom_addr_out}, {29'd0, v.ea});
            if (v.ev) check($sformatf("vec%0d_data", i), bif.block_data_out, v.edat);
            @(negedge clk_in);
        end

        // Stop while presenting, with a hand-off in the same cycle.
        state_in = 2'd1;
        curr_time_in = 18'd0;
        bif.block_ready_in = 1'b0;
        run_until_valid(10, n);
        check("play_latency", n, 32'd4);
        check("play_data", bif.block_data_out, REC0);
        state_in = 2'd3;
        bif.block_ready_in = 1'b1;
        #1;
        check("stop_handoff_pulse", {31'd0, bif.block_position_ready}, 32'd1);
        @(negedge clk_in);
        #1;
        check("stop_state", {29'd0, state_dbg_out}, 32'd0);
        check("stop_addr", {29'd0, rom_addr_out}, 32'd0);
        check("stop_valid", {31'd0, bif.block_valid_out}, 32'd0);
        check("stop_pulse", {31'd0, bif.block_position_ready}, 32'd0);

        // Replay from record 0.
        @(negedge clk_in);
        state_in = 2'd1;
        run_until_valid(10, n);
        check("replay_latency", n, 32'd4);
        check("replay_data", bif.block_data_out, REC0);
        check("replay_addr", {29'd0, rom_addr_out}, 32'd0);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_in = 1'b0;
        #1;
        check("areset_valid", {31'd0, bif.block_valid_out}, 32'd0);
        check("areset_state", {29'd0, state_dbg_out}, 32'd0);
        check("areset_data", bif.block_data_out, 32'd0);
        check("areset_pulse", {31'd0, bif.block_position_ready}, 32'd0);
        @(negedge clk_in);
        state_in = 2'd0;
        bif.block_ready_in = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_in);

        // Lookahead near the top of the time range must not wrap.
        rom_mem[0] = RECW;
        state_in = 2'd1;
        curr_time_in = 18'h3FF00;
        repeat (8) @(negedge clk_in);
        #1;
        check("wrap_not_due_valid", {31'd0, bif.block_valid_out}, 32'd0);
        check("wrap_not_due_state", {29'd0, state_dbg_out}, 32'd2);
        @(negedge clk_in);
        curr_time_in = 18'h3FFA0;
        @(negedge clk_in);
        #1;
        check("wrap_due_valid", {31'd0, bif.block_valid_out}, 32'd1);
        check("wrap_due_data", bif.block_data_out, RECW);
        @(negedge clk_in);
        state_in = 2'd0;
        repeat (2) @(negedge clk_in);

        // Full map without a sentinel: last address ends the walk; early records are stale.
        for (int i = 0; i < NB; i++) begin
            if (i < 3) rom_mem[i] = {18'd10, 14'(i + 1)};
            else       rom_mem[i] = {18'd600, 14'(i + 32)};
        end
`ifdef BEATMAP_DROP_STALE_EN
        for (int i = 3; i < NB; i++) exp_q.push_back(rom_mem[i]);
`else
        for (int i = 0; i < NB; i++) exp_q.push_back(rom_mem[i]);
`endif
        exp_pulses = exp_q.size();
        pulses = 0;
        state_in = 2'd1;
        curr_time_in = 18'd500;
        bif.block_ready_in = 1'b1;
        n = 0;
        #1;
        while (!done_out && n < 100) begin
            if (bif.block_position_ready) begin
                pulses++;
                if (exp_q.size() == 0) check("map_extra_record", bif.block_data_out, 32'd0 - 1);
                else check($sformatf("map_record%0d", pulses), bif.block_data_out, exp_q.pop_front());
            end
            @(negedge clk_in);
            #1;
            n++;
        end
        check("map_done", {31'd0, done_out}, 32'd1);
        check("map_pulses", pulses, exp_pulses);
        check("map_left", exp_q.size(), 32'd0);
        check("map_last_addr", {29'd0, rom_addr_out}, NB - 1);
        check("map_done_valid", {31'd0, bif.block_valid_out}, 32'd0);
`ifdef BEATMAP_DROP_STALE_EN
        check("map_drops", {24'd0, drop_count_out}, 32'd3);
`else
        check("map_drops", {24'd0, drop_count_out}, 32'd0);
`endif
        @(negedge clk_in);
        state_in = 2'd2;
        @(negedge clk_in);
        #1;
        check("won_clears_done", {31'd0, done_out}, 32'd0);
        check("won_clears_drops", {24'd0, drop_count_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
